// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry output register, redirect/kill handling.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect delivers a flagged NOP and halts fetch).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        instr_misaligned
`endif
);

  // state  | meaning
  // S_REQ  | fetch_pc presented; request issued when output can take a new word
  // S_WAIT | request accepted, waiting for rvalid (dropped if r_kill set)
  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_kill;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pcplus4;
  logic        r_instr_valid;

  logic        w_consume;
  logic        w_req;
  logic        w_halt;
  logic [31:0] w_target;

`ifdef FETCH_MISALIGN_EN
  logic r_halt;
  logic r_misaligned;
  logic w_misalign;

  assign w_target         = PCTarget;
  assign w_misalign       = |PCTarget[1:0];
  assign w_halt           = r_halt;
  assign instr_misaligned = r_misaligned;
`else
  assign w_target = {PCTarget[31:2], 2'b00};
  assign w_halt   = 1'b0;
`endif

  always_comb begin
    w_consume = r_instr_valid & ~stall;
    w_req     = (r_state == S_REQ) & ~reset & (~r_instr_valid | ~stall) & ~PCSrc & ~w_halt;
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = r_pcplus4;
  assign instr_valid = r_instr_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_kill        <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_pc          <= RESET_PC;
      r_pcplus4     <= RESET_PC + 32'd4;
      r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      r_halt        <= 1'b0;
      r_misaligned  <= 1'b0;
`endif
    end else if (PCSrc) begin
      r_fetch_pc    <= w_target;
      r_instr_valid <= 1'b0;
      // A response landing in the redirect cycle is simply dropped; otherwise mark the in-flight one dead.
      if (r_state == S_WAIT) begin
        if (imem_rvalid) begin
          r_state <= S_REQ;
          r_kill  <= 1'b0;
        end else begin
          r_kill  <= 1'b1;
        end
      end
`ifdef FETCH_MISALIGN_EN
      r_halt       <= 1'b0;
      r_misaligned <= 1'b0;
      if (w_misalign) begin
        r_instr_valid <= 1'b1;
        r_misaligned  <= 1'b1;
        r_instr       <= NOP;
        r_pc          <= PCTarget;
        r_pcplus4     <= PCTarget + 32'd4;
        r_halt        <= 1'b1;
      end
`endif
    end else begin
      if (w_consume) begin
        r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
        r_misaligned  <= 1'b0;
`endif
      end
      case (r_state)
        S_REQ: begin
          if (w_req && imem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_REQ;
            r_kill  <= 1'b0;
            if (!r_kill) begin
              r_instr       <= imem_rdata;
              r_pc          <= r_fetch_pc;
              r_pcplus4     <= r_fetch_pc + 32'd4;
              r_instr_valid <= 1'b1;
              r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

`ifndef FETCH_MISALIGN_EN
  logic w_unused_nop;
  assign w_unused_nop = ^NOP;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: memory responder + stream-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        stall;
  logic        PCSrc;
  logic [31:0] PCTarget;
`ifdef FETCH_MISALIGN_EN
  logic        instr_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .Instr(Instr),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .instr_valid(instr_valid),
    .stall(stall),
`ifdef FETCH_MISALIGN_EN
    .instr_misaligned(instr_misaligned),
`endif
    .PCSrc(PCSrc),
    .PCTarget(PCTarget)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        mis;
  } exp_t;

  // Delivered-but-unconsumed instructions, in program order.
  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int consumed = 0;
  bit running  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'hC001_D00D;
  endfunction

  // Monitor: checks the output register against the scoreboard each cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (running && !reset) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, (q.size() != 0)});
      if (q.size() != 0 && !stall) begin
        e = q.pop_front();
        chk("pc", PC, e.pc);
        chk("instr", Instr, e.ins);
        chk("pcplus4", PCPlus4, e.pc + 32'd4);
`ifdef FETCH_MISALIGN_EN
        chk("misaligned", {31'b0, instr_misaligned}, {31'b0, e.mis});
`endif
        consumed++;
      end
    end
  end

  initial begin
    bit          outstanding = 1'b0;
    bit          killed      = 1'b0;
    bit          halted      = 1'b0;
    bit          rst_done    = 1'b0;
    bit          post_rst    = 1'b0;
    int          wait_cnt    = 0;
    logic [31:0] out_addr    = '0;
    logic [31:0] exp_next    = RESET_PC;
    bit          do_rst, redirect, stall_v, rv, deliver, mis, exp_req;
    logic [31:0] tgt;

    reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pc", PC, RESET_PC);
    chk("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    running = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      do_rst   = (cyc >= 1500) && !rst_done && outstanding;
      stall_v  = ($urandom_range(0, 9) < 3);
      redirect = !do_rst && ($urandom_range(0, 99) < 7);
      tgt      = $urandom;
      if (cyc == 700 && !do_rst) begin
        redirect = 1'b1;
        tgt      = 32'hFFFF_FFFC;
      end
`ifdef FETCH_MISALIGN_EN
      if (cyc != 700 && $urandom_range(0, 2) != 0) tgt = {tgt[31:2], 2'b00};
`endif
      rv = 1'b0;
      if (outstanding && !do_rst) begin
        wait_cnt--;
        rv = (wait_cnt == 0);
      end
      reset       = do_rst;
      stall       = stall_v;
      PCSrc       = redirect;
      PCTarget    = tgt;
      imem_ready  = ($urandom_range(0, 3) != 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(out_addr) : $urandom;
      #1;

      if (post_rst) begin
        chk("pc_after_reset", PC, RESET_PC);
        chk("valid_after_reset", {31'b0, instr_valid}, 32'h0);
        post_rst = 1'b0;
      end

      exp_req = !do_rst && !outstanding && !redirect && !halted && (q.size() == 0 || !stall_v);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});

      deliver = rv && !killed && !redirect;
      if (rv) begin
        outstanding = 1'b0;
        if (deliver) exp_next = out_addr + 32'd4;
      end
      if (imem_req && imem_ready) begin
        chk("imem_addr", imem_addr, exp_next);
        outstanding = 1'b1;
        killed      = 1'b0;
        out_addr    = imem_addr;
        wait_cnt    = $urandom_range(1, 3);
      end
      mis = 1'b0;
      if (redirect) begin
        if (outstanding) killed = 1'b1;
`ifdef FETCH_MISALIGN_EN
        mis      = (tgt[1:0] != 2'b00);
        exp_next = tgt;
`else
        exp_next = {tgt[31:2], 2'b00};
`endif
        halted = mis;
      end
      if (do_rst) begin
        outstanding = 1'b0;
        killed      = 1'b0;
        halted      = 1'b0;
        exp_next    = RESET_PC;
        rst_done    = 1'b1;
        post_rst    = 1'b1;
      end

      #2;
      if (do_rst || redirect) q.delete();
      if (deliver) q.push_back('{pc: out_addr, ins: mem_word(out_addr), mis: 1'b0});
      if (mis) q.push_back('{pc: tgt, ins: 32'h0000_0013, mis: 1'b1});
    end

    @(negedge clk);
    running = 1'b0;
    chk("progress", {31'b0, (consumed >= 200)}, 32'h1);
    chk("reset_mid_run_seen", {31'b0, rst_done}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
